elastic_pipe_chain: RTL and testbench

Parametrised elastic pipeline register chain: the successor to the fixed-width, enable-only inter-stage `buffer` used between the fetch, decode, execute, memory and writeback stages. It carries `STAGES` registered slots of `WIDTH` bits with valid/ready handshaking and bubble collapsing. It also provides per-slot flush with NOP insertion, a global hold, and occupancy and kill counters. It drops in wherever a multi-cycle inter-stage path needs backpressure, branch/RTI flush and stall handling in one block.

---
 rtl/elastic_pipe_chain.sv | 127 ++++++++++++
 tb/tb_elastic_pipe_chain.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_chain.sv
// elastic_pipe_chain: STAGES-deep valid/ready register chain with bubble
// collapsing, per-slot flush (NOP insertion), global hold, and registered
// occupancy / saturating kill counters. Slot 0 is the input side and slot
// STAGES-1 drives the output.
module elastic_pipe_chain #(
  parameter int               WIDTH     = 64,
  parameter int               STAGES    = 4,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        In_Valid,
  output logic                        In_Ready,
  input  logic [WIDTH-1:0]            In_Data,
  output logic                        Out_Valid,
  input  logic                        Out_Ready,
  output logic [WIDTH-1:0]            Out_Data,
  input  logic [STAGES-1:0]           Flush,
  input  logic                        Hold,
  output logic [$clog2(STAGES+1)-1:0] Count,
  output logic [7:0]                  Kill_Count
);

  localparam int CW = $clog2(STAGES + 1);
  localparam int KW = 9 + CW;  // wide enough for 255 plus one cycle of kills

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] leave;       // slot's item moves downstream (or pops)
  logic [STAGES-1:0] load;        // slot receives an item from upstream
  logic [WIDTH-1:0]  src [STAGES];
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     kills;
  logic [KW-1:0]     kill_sum;
  logic [7:0]        kill_count_q, kill_count_d;

  // Ready ripples from the consumer back to the producer; an empty slot
  // breaks the chain so bubbles collapse. Flush deliberately plays no part.
  always_comb begin
    rdy[STAGES] = Out_Ready & ~Hold;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy[i] = (~valid_q[i] | rdy[i+1]) & ~Hold;
    end
  end

  // Per-slot transfer strobes and the payload each slot would load.
  // NOTE: every variable driven here gets a value before any conditional
  // logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    leave = '0;
    load  = '0;
    for (int i = 0; i < STAGES; i++) begin
      leave[i] = valid_q[i] & ~Flush[i] & rdy[i+1];
    end
    load[0] = In_Valid & rdy[0];
    src[0]  = In_Data;
    for (int i = 1; i < STAGES; i++) begin
      load[i] = leave[i-1];
      src[i]  = data_q[i-1];
    end
  end

  // Slot next state: flush beats hold, hold beats movement; an emptied slot
  // always reverts to NOP_VALUE so invalid slots never carry stale data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < STAGES; i++) begin
      if (Flush[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = NOP_VALUE;
      end else if (!Hold) begin
        if (load[i]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = src[i];
        end else if (leave[i]) begin
          valid_d[i] = 1'b0;
          data_d[i]  = NOP_VALUE;
        end
      end
    end
  end

  // Occupancy of the next state and saturating accumulation of killed items.
  always_comb begin
    count_d = '0;
    kills   = '0;
    for (int i = 0; i < STAGES; i++) begin
      count_d = count_d + CW'(valid_d[i]);
      kills   = kills + CW'(valid_q[i] & Flush[i]);
    end
    kill_sum     = KW'(kill_count_q) + KW'(kills);
    kill_count_d = (kill_sum > KW'(255)) ? 8'hFF : kill_sum[7:0];
  end

  // State registers.
  // NOTE: the payload array is reset as well, because an invalid slot must
  // hold NOP_VALUE and Out_Data is visible straight out of reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q      <= '0;
      count_q      <= '0;
      kill_count_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= NOP_VALUE;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      valid_q      <= valid_d;
      count_q      <= count_d;
      kill_count_q <= kill_count_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign In_Ready   = rdy[0];
  assign Out_Valid  = valid_q[STAGES-1] & ~Flush[STAGES-1] & ~Hold;
  assign Out_Data   = data_q[STAGES-1];
  assign Count      = count_q;
  assign Kill_Count = kill_count_q;

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Testbench for elastic_pipe_chain (WIDTH=16, STAGES=4, NOP=0): directed
// scenarios plus randomized traffic compared against a slot-level model.
module tb_elastic_pipe_chain;

  localparam int W = 16;
  localparam int S = 4;

  logic          Clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [S-1:0]  flush;
  logic          hold;
  logic [2:0]    count;
  logic [7:0]    kill_count;

  int errors = 0;
  int checks = 0;

  // Reference model: slot contents, kill total.
  bit           m_v [S];
  logic [W-1:0] m_d [S];
  int           m_kill;

  elastic_pipe_chain #(.WIDTH(W), .STAGES(S), .NOP_VALUE(16'h0000)) dut (
    .Clk        (Clk),
    .Rst        (rst_n),
    .In_Valid   (in_valid),
    .In_Ready   (in_ready),
    .In_Data    (in_data),
    .Out_Valid  (out_valid),
    .Out_Ready  (out_ready),
    .Out_Data   (out_data),
    .Flush      (flush),
    .Hold       (hold),
    .Count      (count),
    .Kill_Count (kill_count)
  );

  always #5 Clk = ~Clk;

  // A slot's item can advance when anything downstream of it is empty or
  // the consumer is taking the head item.
  function automatic bit m_free_from(int i);
    for (int j = i; j < S; j++) if (!m_v[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_in_ready();
    return !hold && (out_ready || m_free_from(0));
  endfunction

  function automatic bit m_out_valid();
    return m_v[S-1] && !flush[S-1] && !hold;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < S; i++) c += int'(m_v[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < S; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end
    m_kill = 0;
  endtask

  // One clock: evaluate the model against the inputs held across the edge,
  // wait for the edge, commit the model, then settle 1 time unit.
  task automatic cycle();
    bit           mv [S];
    bit           acc;
    logic [W-1:0] acc_data;
    bit           nv [S];
    logic [W-1:0] nd [S];
    #1;
    for (int i = 0; i < S; i++)
      mv[i] = m_v[i] && !flush[i] && !hold && (out_ready || m_free_from(i + 1));
    acc      = in_valid && m_in_ready();
    acc_data = in_data;
    @(posedge Clk);
    nv = m_v;
    nd = m_d;
    for (int i = 0; i < S; i++) if (mv[i]) begin nv[i] = 1'b0; nd[i] = '0; end
    if (acc) begin nv[0] = 1'b1; nd[0] = acc_data; end
    for (int i = 1; i < S; i++) if (mv[i-1]) begin nv[i] = 1'b1; nd[i] = m_d[i-1]; end
    for (int i = 0; i < S; i++) if (flush[i]) begin
      if (m_v[i]) m_kill++;
      nv[i] = 1'b0;
      nd[i] = '0;
    end
    if (m_kill > 255) m_kill = 255;
    m_v = nv;
    m_d = nd;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (kill_count !== 8'd0) begin errors++; $display("FAIL reset_kill: got %0d want 0", kill_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    logic [W-1:0] pushes [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic [W-1:0] exp_d  [7] = '{16'h0, 16'h0, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h0};
    bit           exp_v  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int peak = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k < 3);
      in_data  = '0;
      if (k < 3) in_data = pushes[k];
      cycle();
      checks++; if (out_valid !== exp_v[k]) begin errors++; $display("FAIL stream_valid[%0d]: got %b want %b", k, out_valid, exp_v[k]); end
      checks++; if (out_data !== exp_d[k]) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", k, out_data, exp_d[k]); end
      if (int'(count) > peak) peak = int'(count);
    end
    in_valid = 1'b0;
    checks++; if (peak != 3) begin errors++; $display("FAIL stream_count_peak: got %0d want 3", peak); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 16'hA000 + 16'(acc);
      #1;
      if (in_ready) acc++;
      cycle();
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count_full: got %0d want 4", count); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (out_data !== 16'hA000 + 16'(k)) begin errors++; $display("FAIL bp_drain_data[%0d]: got %h want %h", k, out_data, 16'hA000 + 16'(k)); end
      cycle();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL bp_count_empty: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    logic [W-1:0] q [$];
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 16'hB000 + 16'(k);
      cycle();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL flush_count_before: got %0d want 4", count); end
    flush = 4'b0011;
    cycle();
    flush = '0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL flush_count_after: got %0d want 2", count); end
    checks++; if (kill_count !== 8'd2) begin errors++; $display("FAIL flush_kill: got %0d want 2", kill_count); end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (out_valid) q.push_back(out_data);
      cycle();
    end
    checks++; if (q.size() != 2) begin errors++; $display("FAIL flush_pop_count: got %0d want 2", q.size()); end
    for (int i = 0; i < 2 && i < q.size(); i++) begin
      checks++; if (q[i] !== 16'hB000 + 16'(i)) begin errors++; $display("FAIL flush_pop[%0d]: got %h want %h", i, q[i], 16'hB000 + 16'(i)); end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] q [$];
    int acc = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (acc < 8);
      in_data  = 16'hC000 + 16'(acc);
      hold     = (c >= 3 && c < 6);
      #1;
      if (hold) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", c, in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_out_valid[%0d]: got %b want 0", c, out_valid); end
        checks++; if (count !== 3'(m_count())) begin errors++; $display("FAIL hold_count[%0d]: got %0d want %0d", c, count, m_count()); end
      end
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) q.push_back(out_data);
      cycle();
    end
    hold     = 1'b0;
    in_valid = 1'b0;
    checks++; if (q.size() != 8) begin errors++; $display("FAIL hold_stream_len: got %0d want 8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      checks++; if (q[i] !== 16'hC000 + 16'(i)) begin errors++; $display("FAIL hold_stream[%0d]: got %h want %h", i, q[i], 16'hC000 + 16'(i)); end
    end
  endtask

  task automatic test_hold_flush();
    logic [W-1:0] q [$];
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 16'hD000 + 16'(k);
      cycle();
    end
    in_valid = 1'b0;
    hold     = 1'b1;
    flush    = 4'b1000;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hf_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hf_in_ready: got %b want 0", in_ready); end
    cycle();
    hold  = 1'b0;
    flush = '0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL hf_count: got %0d want 3", count); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL hf_out_nop: got %h want 0000", out_data); end
    checks++; if (kill_count !== 8'd3) begin errors++; $display("FAIL hf_kill: got %0d want 3", kill_count); end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (out_valid) q.push_back(out_data);
      cycle();
    end
    checks++; if (q.size() != 3) begin errors++; $display("FAIL hf_pop_count: got %0d want 3", q.size()); end
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      checks++; if (q[i] !== 16'hD001 + 16'(i)) begin errors++; $display("FAIL hf_pop[%0d]: got %h want %h", i, q[i], 16'hD001 + 16'(i)); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      hold      = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < S; i++) flush[i] = ($urandom_range(0, 9) == 0);
      #1;
      checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_ready, m_in_ready()); end
      checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", c, out_valid, m_out_valid()); end
      checks++; if (out_data !== m_d[S-1]) begin errors++; $display("FAIL rnd_out_data[%0d]: got %h want %h", c, out_data, m_d[S-1]); end
      cycle();
      checks++; if (count !== 3'(m_count())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count, m_count()); end
      checks++; if (kill_count !== 8'(m_kill)) begin errors++; $display("FAIL rnd_kill[%0d]: got %0d want %0d", c, kill_count, m_kill); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    hold      = 1'b0;
    flush     = '0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 16'hE000 + 16'(k);
      cycle();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ar_full_count: got %0d want 4", count); end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid: got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", count); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL ar_out_data: got %h want 0000", out_data); end
    @(posedge Clk);
    #2;
    rst_n = 1'b1;
    checks++; if (kill_count !== 8'd0) begin errors++; $display("FAIL ar_kill: got %0d want 0", kill_count); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hF000;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      checks++; if (out_valid !== (k == 3)) begin errors++; $display("FAIL ar_latency_valid[%0d]: got %b want %b", k, out_valid, (k == 3)); end
      if (k == 3) begin
        checks++; if (out_data !== 16'hF000) begin errors++; $display("FAIL ar_latency_data: got %h want f000", out_data); end
      end
    end
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_kill_saturation();
    int expk;
    out_ready = 1'b0;
    for (int r = 0; r < 75; r++) begin
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
        in_data = 16'(r * 4 + k);
        cycle();
      end
      in_valid = 1'b0;
      flush    = 4'hF;
      cycle();
      flush = '0;
      expk  = (4 * (r + 1) > 255) ? 255 : 4 * (r + 1);
      checks++; if (kill_count !== 8'(expk)) begin errors++; $display("FAIL kill_sat[%0d]: got %0d want %0d", r, kill_count, expk); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = '0;
    hold      = 1'b0;
    m_reset();
    repeat (2) @(posedge Clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_hold();
    test_hold_flush();
    test_random();
    test_async_reset();
    test_kill_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog timeout");
  end

endmodule
